crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised streaming CRC generator: the sequential, multi-bit successor of the XOR
//  gate. It folds DATA_W-bit words into a CRC_W-bit XOR-feedback register, one word per
//  clock, under valid/ready flow control. It presents the final CRC on a held result
//  handshake. It sits between a byte/word source (UART, memory reader) and its consumer.
// PARAMETERS
//  DATA_W   8        input word width, bits (>=1)
//  CRC_W    16       CRC register width, bits (>=2)
//  POLY     16'h1021 generator polynomial, implicit x^CRC_W term omitted
//  INIT     16'hFFFF register value at reset, after frame end, and after abort
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  in_valid    in   1       in_data/in_last are valid
//  in_ready    out  1       engine accepts a word this cycle
//  in_data     in   DATA_W  data word, MSB processed first
//  in_last     in   1       word is the last of the frame
//  abort       in   1       discard the current frame
//  crc_out     out  CRC_W   final CRC, stable while crc_valid=1
//  crc_valid   out  1       result available
//  crc_ack     in   1       consumer takes the result
//  word_count  out  16      words accepted in the current/finished frame (saturates 16'hFFFF)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=ACCUM, crc=INIT, crc_out=0, crc_valid=0,
//    word_count=0, in_ready=1 on the first edge after release.
//  - Word update, combinational over DATA_W bits, i=DATA_W-1..0:
//    fb=crc[CRC_W-1]^d[i]; crc=(crc<<1)^(fb?POLY:0). Truncate to CRC_W bits.
//  - FSM ACCUM: in_ready=1. On in_valid&in_ready: crc<=update, word_count+=1.
//    If in_last is also set: crc_out<=update, crc_valid<=1, crc<=INIT, go to HOLD.
//    Latency: last word accepted at edge N -> crc_valid=1 after edge N. No bubbles:
//    one word per cycle sustained.
//  - FSM HOLD: in_ready=0, crc_out/crc_valid/word_count held. On crc_ack: crc_valid<=0,
//    word_count<=0, go to ACCUM. in_ready=1 the cycle after the ack edge.
//  - crc_ack while crc_valid=0 is ignored. in_valid in HOLD is not accepted (source waits).
//  - abort in ACCUM: crc<=INIT, word_count<=0. It has priority over a simultaneous
//    in_valid/in_last, and that word is dropped. abort in HOLD is ignored; the result
//    survives until acked.
//  - Single-word frame (in_last on first word) is legal. A zero-word frame is impossible.
//  - Reset mid-frame or mid-HOLD: immediate return to reset values; the result is lost.
// CONFIGURATION
//  CRC_REFLECT_EN defined: each in_data word is bit-reversed before update, and crc_out
//    is the bit-reverse of the final register (LSB-first CRCs, e.g. MCRF4XX/X-25 core).
//  Not defined: no reflection; data is MSB-first and crc_out is the raw register.
//  No other behaviour changes. Handshake and latency are identical in both builds.
// TESTING
//  1 Defaults, ASCII "123456789" streamed back-to-back, last on '9' -> crc_out=16'h29B1,
//    crc_valid after 9th edge, word_count=9, in_ready=0 until crc_ack.
//  2 Single word 8'h41 with in_last -> crc_out=16'hB915, word_count=1. Ack, then repeat
//    the same word -> 16'hB915 again (INIT restored).
//  3 CRC_REFLECT_EN, "123456789" -> crc_out=16'h6F91.
//  4 Stream "1234", abort together with in_valid on '5', then full "123456789"
//    -> 16'h29B1, word_count=9.
//  5 Hold crc_valid 5 cycles with crc_ack=0 while in_valid=1 and abort pulses
//    -> crc_out stable, no word accepted. crc_ack pulse -> crc_valid=0 next cycle.
//  6 Assert reset mid-frame after 4 words, async (between edges) -> outputs reach reset
//    values without a clock edge. Then "123456789" -> 16'h29B1.

Source files
------------

// File: rtl/crc_stream_engine_if.sv
// Word-stream and result handshake bundle for crc_stream_engine.
// master: word source + result consumer side; slave: the engine.
interface crc_stream_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              abort;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_valid;
  logic              crc_ack;
  logic [15:0]       word_count;

  modport master (
    output in_valid, in_data, in_last, abort, crc_ack,
    input  in_ready, crc_out, crc_valid, word_count
  );

  modport slave (
    input  in_valid, in_data, in_last, abort, crc_ack,
    output in_ready, crc_out, crc_valid, word_count
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: folds one DATA_W-bit word per clock into a CRC_W-bit
// XOR-feedback register and holds the final CRC until the consumer acks it.
// Build option: define CRC_REFLECT_EN for LSB-first CRCs (data words and the
// final register are bit-reversed); otherwise data is MSB-first, output raw.
module crc_stream_engine #(
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT   = CRC_W'(16'hFFFF)
) (
  input logic                clk,
  input logic                reset,
  crc_stream_engine_if.slave strm
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e            state_q;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CRC_W-1:0]  crc_out_q, res_d;
  logic              crc_valid_q;
  logic              in_ready_q;
  logic [15:0]       count_q, count_d;
  logic [DATA_W-1:0] data_w;
  logic              accept;

  // Bitwise MSB-first LFSR fold of one word into the register.
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc,
                                                  input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

`ifdef CRC_REFLECT_EN
  function automatic logic [DATA_W-1:0] rev_data(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W); i++) r[i] = d[int'(DATA_W) - 1 - i];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < int'(CRC_W); i++) r[i] = c[int'(CRC_W) - 1 - i];
    return r;
  endfunction
`endif

  // Next register value, result candidate and saturating word count.
  always_comb begin
`ifdef CRC_REFLECT_EN
    data_w = rev_data(strm.in_data);
    crc_d  = crc_update(crc_q, data_w);
    res_d  = rev_crc(crc_d);
`else
    data_w = strm.in_data;
    crc_d  = crc_update(crc_q, data_w);
    res_d  = crc_d;
`endif
    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    // in_ready_q is only ever set while accumulating.
    accept  = strm.in_valid & in_ready_q;
  end

  // Frame FSM with registered handshake/result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StAccum;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          in_ready_q <= 1'b1;
          if (strm.abort) begin
            // Abort wins over a word presented in the same cycle.
            crc_q   <= INIT;
            count_q <= '0;
          end else if (accept) begin
            count_q <= count_d;
            if (strm.in_last) begin
              crc_out_q   <= res_d;
              crc_valid_q <= 1'b1;
              crc_q       <= INIT;
              in_ready_q  <= 1'b0;
              state_q     <= StHold;
            end else begin
              crc_q <= crc_d;
            end
          end
        end
        StHold: begin
          // crc_valid is always set here, so the ack is never a stray one.
          if (strm.crc_ack) begin
            crc_valid_q <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign strm.in_ready   = in_ready_q;
  assign strm.crc_out    = crc_out_q;
  assign strm.crc_valid  = crc_valid_q;
  assign strm.word_count = count_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed self-checking bench for crc_stream_engine (default CRC-16/CCITT-FALSE
// parameters; expectations switch to the MCRF4XX values in the reflected build).
module tb_crc_stream_engine;

`ifdef CRC_REFLECT_EN
  localparam logic [15:0] ExpMsg = 16'h6F91;
  localparam logic [15:0] ExpA   = 16'h5C0A;
`else
  localparam logic [15:0] ExpMsg = 16'h29B1;
  localparam logic [15:0] ExpA   = 16'hB915;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc_stream_engine_if #(.DATA_W(8), .CRC_W(16)) strm ();

  crc_stream_engine #(
    .DATA_W(8),
    .CRC_W (16),
    .POLY  (16'h1021),
    .INIT  (16'hFFFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .strm (strm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one word from a negedge; returns at the negedge after it is taken.
  task automatic put(input logic [7:0] d, input logic last);
    int waits;
    waits = 0;
    strm.in_valid = 1'b1;
    strm.in_data  = d;
    strm.in_last  = last;
    while (!strm.in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) check_eq("put_ready_timeout", 32'(strm.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_msg(input int n, input logic last_on_end, output int cycles);
    int c0;
    c0 = cyc;
    for (int i = 0; i < n; i++) put(msg[i], last_on_end && (i == n - 1));
    cycles = cyc - c0;
    strm.in_valid = 1'b0;
    strm.in_last  = 1'b0;
  endtask

  task automatic ack_result(input string tag);
    strm.crc_ack = 1'b1;
    @(negedge clk);
    strm.crc_ack = 1'b0;
    check_eq({tag, "_ack_valid"}, 32'(strm.crc_valid), 32'd0);
    check_eq({tag, "_ack_ready"}, 32'(strm.in_ready), 32'd1);
    check_eq({tag, "_ack_count"}, 32'(strm.word_count), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] crc, input int cnt);
    check_eq({tag, "_crc"}, 32'(strm.crc_out), 32'(crc));
    check_eq({tag, "_valid"}, 32'(strm.crc_valid), 32'd1);
    check_eq({tag, "_count"}, 32'(strm.word_count), 32'(cnt));
    check_eq({tag, "_ready"}, 32'(strm.in_ready), 32'd0);
  endtask

  initial begin
    int cycles;
    strm.in_valid = 1'b0;
    strm.in_data  = '0;
    strm.in_last  = 1'b0;
    strm.abort    = 1'b0;
    strm.crc_ack  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(strm.crc_valid), 32'd0);
    check_eq("rst_crc_out", 32'(strm.crc_out), 32'd0);
    check_eq("rst_count", 32'(strm.word_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_after_edge", 32'(strm.in_ready), 32'd1);

    // 1: "123456789" back-to-back
    send_msg(9, 1'b1, cycles);
    check_eq("t1_cycles", 32'(cycles), 32'd9);
    check_result("t1", ExpMsg, 9);

    // 5: held result ignores in_valid and abort pulses
    strm.in_valid = 1'b1;
    strm.in_data  = 8'hAA;
    strm.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strm.abort = i[0];
      @(negedge clk);
      check_result("t5_hold", ExpMsg, 9);
    end
    strm.abort    = 1'b0;
    strm.in_valid = 1'b0;
    strm.in_last  = 1'b0;
    ack_result("t5");

    // 2: single-word frame, twice (INIT restored between frames)
    put(8'h41, 1'b1);
    strm.in_valid = 1'b0;
    check_result("t2a", ExpA, 1);
    ack_result("t2a");
    put(8'h41, 1'b1);
    strm.in_valid = 1'b0;
    check_result("t2b", ExpA, 1);
    ack_result("t2b");

    // 4: abort together with the 5th word, then a full frame
    send_msg(4, 1'b0, cycles);
    check_eq("t4_partial_count", 32'(strm.word_count), 32'd4);
    strm.in_valid = 1'b1;
    strm.in_data  = msg[4];
    strm.abort    = 1'b1;
    @(negedge clk);
    strm.in_valid = 1'b0;
    strm.abort    = 1'b0;
    check_eq("t4_abort_count", 32'(strm.word_count), 32'd0);
    check_eq("t4_abort_valid", 32'(strm.crc_valid), 32'd0);
    send_msg(9, 1'b1, cycles);
    check_result("t4", ExpMsg, 9);
    ack_result("t4");

    // Stray ack while accumulating must not disturb the frame
    send_msg(4, 1'b0, cycles);
    strm.crc_ack = 1'b1;
    @(negedge clk);
    strm.crc_ack = 1'b0;
    check_eq("stray_ack_count", 32'(strm.word_count), 32'd4);
    check_eq("stray_ack_valid", 32'(strm.crc_valid), 32'd0);

    // 6: asynchronous reset mid-frame, between edges
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_count", 32'(strm.word_count), 32'd0);
    check_eq("t6_async_ready", 32'(strm.in_ready), 32'd0);
    check_eq("t6_async_valid", 32'(strm.crc_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_msg(9, 1'b1, cycles);
    check_result("t6", ExpMsg, 9);
    ack_result("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
